// File: rtl/draw_scheduler.sv
// draw_scheduler: fetches shape commands, starts rect/tri/circle engines and merges their pixels into one framebuffer write port (frame/cmd_* in, cmd_addr/start_*/v*/oe to engines, drawing_*/done_*/x_*/y_* from engines, fb_busy in, fb_we/fbx/fby/fb_cidx out, busy/done status)
module draw_scheduler #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4,
  parameter int SHAPE_CNT = 19,
  parameter int CMDAW = 5,
  parameter int FRAME_WAIT = 300,
  parameter int PIX_FRAME = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  output logic [CMDAW-1:0] cmd_addr,
  input  logic [1:0]       cmd_type,
  input  logic [CORDW-1:0] cmd_x0,
  input  logic [CORDW-1:0] cmd_y0,
  input  logic [CORDW-1:0] cmd_x1,
  input  logic [CORDW-1:0] cmd_y1,
  input  logic [CORDW-1:0] cmd_x2,
  input  logic [CORDW-1:0] cmd_y2,
  input  logic [CORDW-1:0] cmd_r0,
  input  logic [CIDXW-1:0] cmd_cidx,
  output logic             start_rect,
  output logic             start_tri,
  output logic             start_circle,
  output logic [CORDW-1:0] vx0,
  output logic [CORDW-1:0] vy0,
  output logic [CORDW-1:0] vx1,
  output logic [CORDW-1:0] vy1,
  output logic [CORDW-1:0] vx2,
  output logic [CORDW-1:0] vy2,
  output logic [CORDW-1:0] vr0,
  output logic             oe,
  input  logic             drawing_rect,
  input  logic             drawing_tri,
  input  logic             drawing_circle,
  input  logic             done_rect,
  input  logic             done_tri,
  input  logic             done_circle,
  input  logic [CORDW-1:0] x_rect,
  input  logic [CORDW-1:0] y_rect,
  input  logic [CORDW-1:0] x_tri,
  input  logic [CORDW-1:0] y_tri,
  input  logic [CORDW-1:0] x_circle,
  input  logic [CORDW-1:0] y_circle,
  input  logic             fb_busy,
  output logic             fb_we,
  output logic [CORDW-1:0] fbx,
  output logic [CORDW-1:0] fby,
  output logic [CIDXW-1:0] fb_cidx,
  output logic             busy,
  output logic             done
);
  localparam int FW = $clog2(FRAME_WAIT + 1);
  localparam int PW = $clog2(PIX_FRAME + 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, DRAW, DONE} state_t;
  state_t state_q, state_d;
  logic [CMDAW-1:0] cmd_addr_q, cmd_addr_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [1:0] act_q, act_d;
  logic [6:0][CORDW-1:0] par_q, par_d;
  logic [CIDXW-1:0] cidx_q, cidx_d;
  logic [2:0] start_q, start_d;
  logic fb_we_q, fb_we_d;
  logic [CORDW-1:0] fbx_q, fbx_d, fby_q, fby_d;
  logic done_act, drw_act;
  assign done_act = act_q == 2'd0 ? done_rect : act_q == 2'd1 ? done_tri : done_circle;
  assign drw_act = act_q == 2'd0 ? drawing_rect : act_q == 2'd1 ? drawing_tri : drawing_circle;
  assign oe = state_q == DRAW && !fb_busy && pix_cnt_q < PW'(PIX_FRAME);
  always_comb begin
    state_d = state_q;
    cmd_addr_d = cmd_addr_q;
    fcnt_d = fcnt_q;
    act_d = act_q;
    par_d = par_q;
    cidx_d = cidx_q;
    start_d = '0;
    case (state_q)
      IDLE: if (frame) begin
        fcnt_d = fcnt_q == FW'(FRAME_WAIT) ? fcnt_q : fcnt_q + FW'(1);
        if (fcnt_d == FW'(FRAME_WAIT)) begin
          state_d = FETCH;
          cmd_addr_d = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: if (cmd_type == 2'b11) state_d = DONE;
      else begin
        par_d = {cmd_r0, cmd_y2, cmd_x2, cmd_y1, cmd_x1, cmd_y0, cmd_x0};
        cidx_d = cmd_cidx;
        act_d = cmd_type;
        start_d = 3'b001 << cmd_type;
        state_d = DRAW;
      end
      DRAW: if (done_act) begin
        state_d = cmd_addr_q == CMDAW'(SHAPE_CNT - 1) ? DONE : FETCH;
        cmd_addr_d = cmd_addr_q == CMDAW'(SHAPE_CNT - 1) ? cmd_addr_q : cmd_addr_q + CMDAW'(1);
      end
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // a pixel granted on the frame pulse already belongs to the new frame
  always_comb begin
    pix_cnt_d = frame ? PW'(oe) : pix_cnt_q + PW'(oe);
    fb_we_d = drw_act && state_q == DRAW;
    fbx_d = act_q == 2'd0 ? x_rect : act_q == 2'd1 ? x_tri : x_circle;
    fby_d = act_q == 2'd0 ? y_rect : act_q == 2'd1 ? y_tri : y_circle;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_addr_q <= '0;
      fcnt_q <= '0;
      pix_cnt_q <= '0;
      act_q <= '0;
      par_q <= '0;
      cidx_q <= '0;
      start_q <= '0;
      fb_we_q <= 1'b0;
      fbx_q <= '0;
      fby_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_addr_q <= cmd_addr_d;
      fcnt_q <= fcnt_d;
      pix_cnt_q <= pix_cnt_d;
      act_q <= act_d;
      par_q <= par_d;
      cidx_q <= cidx_d;
      start_q <= start_d;
      fb_we_q <= fb_we_d;
      fbx_q <= fbx_d;
      fby_q <= fby_d;
    end
  end
  assign cmd_addr = cmd_addr_q;
  assign {start_circle, start_tri, start_rect} = start_q;
  assign {vr0, vy2, vx2, vy1, vx1, vy0, vx0} = par_q;
  assign fb_cidx = cidx_q;
  assign fb_we = fb_we_q;
  assign fbx = fbx_q;
  assign fby = fby_q;
  assign busy = state_q == FETCH || state_q == LOAD || state_q == DRAW;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: directed bench for draw_scheduler with a 3-command list, engine models, a pixel scoreboard and an end-of-list instance
module tb_draw_scheduler;
  localparam int CW = 16;
  localparam int IW = 4;
  localparam int LEN[3] = '{10, 3, 5};
  localparam int XB[3] = '{200, 300, 400};
  localparam int YB[3] = '{5, 6, 7};
  localparam int CI[3] = '{3, 7, 11};
  logic clk = 1'b0, rst = 1'b1, frame = 1'b0, fb_busy = 1'b0, spur = 1'b0;
  always #5 clk = ~clk;
  logic [4:0] cmd_addr;
  logic [1:0] cmd_type;
  logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2, cmd_r0;
  logic [IW-1:0] cmd_cidx;
  logic start_rect, start_tri, start_circle, oe, fb_we, busy, done;
  logic [CW-1:0] vx0, vy0, vx1, vy1, vx2, vy2, vr0, fbx, fby;
  logic [IW-1:0] fb_cidx;
  logic drawing_rect, drawing_tri, drawing_circle, done_rect, done_tri, done_circle;
  logic [CW-1:0] x_rect, y_rect, x_tri, y_tri, x_circle, y_circle;
  logic [2:0] st, drw, dn;
  int rem[3], idx[3], cr[3], ci[3];
  int nchk = 0, nfail = 0;
  int cyc = 0, done_cyc = 0, nwe = 0, oe_cnt = 0, nb_start = 0;
  bit have_done = 1'b0;
  logic [1:0] seq[$];
  logic [35:0] sb[$];
  draw_scheduler #(.FRAME_WAIT(2), .SHAPE_CNT(3), .PIX_FRAME(4)) dut (
    .clk(clk), .rst(rst), .frame(frame), .cmd_addr(cmd_addr), .cmd_type(cmd_type),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_x2(cmd_x2), .cmd_y2(cmd_y2), .cmd_r0(cmd_r0), .cmd_cidx(cmd_cidx),
    .start_rect(start_rect), .start_tri(start_tri), .start_circle(start_circle),
    .vx0(vx0), .vy0(vy0), .vx1(vx1), .vy1(vy1), .vx2(vx2), .vy2(vy2), .vr0(vr0), .oe(oe),
    .drawing_rect(drawing_rect), .drawing_tri(drawing_tri), .drawing_circle(drawing_circle),
    .done_rect(done_rect), .done_tri(done_tri), .done_circle(done_circle),
    .x_rect(x_rect), .y_rect(y_rect), .x_tri(x_tri), .y_tri(y_tri),
    .x_circle(x_circle), .y_circle(y_circle), .fb_busy(fb_busy), .fb_we(fb_we),
    .fbx(fbx), .fby(fby), .fb_cidx(fb_cidx), .busy(busy), .done(done)
  );
  logic [4:0] b_cmd_addr;
  logic [1:0] b_cmd_type;
  logic b_start_rect, b_start_tri, b_start_circle, b_oe, b_fb_we, b_busy, b_done, b_done_rect;
  logic [CW-1:0] b_vx0, b_vy0, b_vx1, b_vy1, b_vx2, b_vy2, b_vr0, b_fbx, b_fby;
  logic [IW-1:0] b_fb_cidx;
  logic [CW-1:0] z16 = '0;
  logic [IW-1:0] z4 = '0;
  logic z1 = 1'b0;
  draw_scheduler #(.FRAME_WAIT(2)) dut_b (
    .clk(clk), .rst(rst), .frame(frame), .cmd_addr(b_cmd_addr), .cmd_type(b_cmd_type),
    .cmd_x0(z16), .cmd_y0(z16), .cmd_x1(z16), .cmd_y1(z16), .cmd_x2(z16), .cmd_y2(z16),
    .cmd_r0(z16), .cmd_cidx(z4),
    .start_rect(b_start_rect), .start_tri(b_start_tri), .start_circle(b_start_circle),
    .vx0(b_vx0), .vy0(b_vy0), .vx1(b_vx1), .vy1(b_vy1), .vx2(b_vx2), .vy2(b_vy2), .vr0(b_vr0),
    .oe(b_oe), .drawing_rect(z1), .drawing_tri(z1), .drawing_circle(z1),
    .done_rect(b_done_rect), .done_tri(z1), .done_circle(z1),
    .x_rect(z16), .y_rect(z16), .x_tri(z16), .y_tri(z16), .x_circle(z16), .y_circle(z16),
    .fb_busy(z1), .fb_we(b_fb_we), .fbx(b_fbx), .fby(b_fby), .fb_cidx(b_fb_cidx),
    .busy(b_busy), .done(b_done)
  );
  always @(posedge clk) begin
    cmd_type <= cmd_addr < 5'd3 ? cmd_addr[1:0] : 2'b11;
    cmd_x0 <= CW'(10 + 100 * int'(cmd_addr));
    cmd_y0 <= CW'(20 + int'(cmd_addr));
    cmd_x1 <= CW'(30 + int'(cmd_addr));
    cmd_y1 <= CW'(40 + int'(cmd_addr));
    cmd_x2 <= CW'(50 + int'(cmd_addr));
    cmd_y2 <= CW'(60 + int'(cmd_addr));
    cmd_r0 <= CW'(7 + int'(cmd_addr));
    cmd_cidx <= IW'(3 + 4 * int'(cmd_addr));
    b_cmd_type <= b_cmd_addr == 5'd0 ? 2'b00 : 2'b11;
    b_done_rect <= rst ? 1'b0 : b_start_rect;
  end
  assign st = {start_circle, start_tri, start_rect};
  always_comb begin
    for (int e = 0; e < 3; e++) begin
      cr[e] = st[e] ? LEN[e] : rem[e];
      ci[e] = st[e] ? 0 : idx[e];
      drw[e] = oe && cr[e] != 0;
      dn[e] = drw[e] && cr[e] == 1;
    end
  end
  always @(posedge clk) begin
    for (int e = 0; e < 3; e++) begin
      rem[e] <= rst ? 0 : cr[e] - int'(drw[e]);
      idx[e] <= rst ? 0 : ci[e] + int'(drw[e]);
    end
  end
  assign {drawing_circle, drawing_tri, drawing_rect} = drw;
  assign done_rect = dn[0];
  assign done_tri = dn[1] | spur;
  assign done_circle = dn[2];
  assign x_rect = CW'(XB[0] + ci[0]);
  assign x_tri = CW'(XB[1] + ci[1]);
  assign x_circle = CW'(XB[2] + ci[2]);
  assign y_rect = CW'(YB[0]);
  assign y_tri = CW'(YB[1]);
  assign y_circle = CW'(YB[2]);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    oe_cnt = frame ? int'(oe) : oe_cnt + int'(oe);
    if (fb_we) begin
      nwe++;
      chk("fb_pending", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) chk("fb_pix", {fbx, fby, fb_cidx}, sb.pop_front());
    end
    if (|st) begin
      seq.push_back(start_tri ? 2'd1 : start_circle ? 2'd2 : 2'd0);
      if (have_done) chk("b2b", cyc - done_cyc, 3);
    end
    if (|dn) begin
      done_cyc = cyc;
      have_done = 1'b1;
    end
    for (int e = 0; e < 3; e++)
      if (drw[e]) sb.push_back({CW'(XB[e] + ci[e]), CW'(YB[e]), IW'(CI[e])});
    if (b_start_rect | b_start_tri | b_start_circle) nb_start++;
    if (rst) begin
      sb.delete();
      have_done = 1'b0;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_frame;
    frame = 1'b1;
    tick(1);
    frame = 1'b0;
  endtask
  initial begin
    tick(3);
    chk("rst_flags", {busy, done, oe, fb_we, start_rect, start_tri, start_circle}, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_regs", {vx0, vr0, fb_cidx, fbx}, 0);
    rst = 1'b0;
    tick(2);
    pulse_frame();
    tick(5);
    chk("wait1_busy", busy, 0);
    chk("wait1_starts", seq.size(), 0);
    pulse_frame();
    chk("fetch_lat", busy, 1);
    chk("fetch_addr", cmd_addr, 0);
    tick(1);
    chk("load_nostart", st, 3'b000);
    tick(1);
    chk("start_rect", st, 3'b001);
    chk("vpar0", {vx0, vy0, vx1, vy1}, {16'd10, 16'd20, 16'd30, 16'd40});
    chk("vpar1", {vx2, vy2, vr0}, {16'd50, 16'd60, 16'd7});
    chk("cidx", fb_cidx, 3);
    tick(1);
    chk("start_1cyc", st, 3'b000);
    tick(20);
    chk("oe_frame_a", oe_cnt, 4);
    chk("we_frame_a", nwe, 4);
    chk("oe_budget", oe, 0);
    fb_busy = 1'b1;
    frame = 1'b1;
    #1 chk("busy_oe", oe, 0);
    tick(1);
    frame = 1'b0;
    repeat (4) begin
      chk("busy_oe", oe, 0);
      tick(1);
    end
    fb_busy = 1'b0;
    #1 chk("busy_release_oe", oe, 1);
    tick(20);
    chk("oe_frame_b", oe_cnt, 4);
    chk("we_frame_b", nwe, 8);
    pulse_frame();
    tick(20);
    chk("oe_frame_c", oe_cnt, 4);
    chk("we_frame_c", nwe, 12);
    chk("addr_c", cmd_addr, 1);
    pulse_frame();
    tick(20);
    chk("oe_frame_d", oe_cnt, 4);
    chk("we_frame_d", nwe, 16);
    chk("addr_d", cmd_addr, 2);
    spur = 1'b1;
    tick(1);
    spur = 1'b0;
    tick(2);
    chk("spur_addr", cmd_addr, 2);
    chk("spur_state", {busy, done}, 2'b10);
    chk("spur_starts", seq.size(), 3);
    pulse_frame();
    tick(20);
    chk("oe_frame_e", oe_cnt, 2);
    chk("we_total", nwe, 18);
    chk("list_done", {busy, done}, 2'b01);
    chk("sb_empty", sb.size(), 0);
    chk("start_order", seq.size() == 3 ? {seq[0], seq[1], seq[2]} : 6'h3f, {2'd0, 2'd1, 2'd2});
    chk("eol_done", b_done, 1);
    chk("eol_addr", b_cmd_addr, 1);
    chk("eol_starts", nb_start, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    pulse_frame();
    pulse_frame();
    tick(3);
    chk("redraw_oe", oe, 1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_flags", {busy, done, oe, fb_we, st}, 0);
    chk("mid_rst_regs", {vx0, fbx, fby, fb_cidx}, 0);
    chk("mid_rst_addr", cmd_addr, 0);
    rst = 1'b0;
    tick(3);
    pulse_frame();
    tick(5);
    chk("rst_wait_busy", busy, 0);
    pulse_frame();
    chk("rst_resume", busy, 1);
    tick(2);
    chk("rst_restart", st, 3'b001);
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
